// File: rtl/custom_controller_device_pkg.sv
// custom_controller_pkg: shared state type and constants for the controller-side serial responder
package custom_controller_pkg;
  typedef enum logic [1:0] {LOAD, SHIFT, DONE} ctrl_dev_state_t;
  localparam int CTRL_NUM_BUTTONS = 8;
  localparam logic CTRL_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/custom_controller_device_if.sv
// custom_controller_device_if: host link signals between the host reader and the controller responder
interface custom_controller_device_if import custom_controller_pkg::*; #(
  parameter int NUM_BUTTONS = CTRL_NUM_BUTTONS
);
  logic                   latch;
  logic                   pulse;
  logic [NUM_BUTTONS-1:0] btn_in;
  logic                   data;
  logic                   busy;
  logic                   frame_done;
  modport master (output latch, pulse, btn_in, input data, busy, frame_done);
  modport slave  (input latch, pulse, btn_in, output data, busy, frame_done);
endinterface

// File: rtl/custom_controller_device_conditioner.sv
// ctrl_input_conditioner: synchronizer, glitch filter and edge-detect register for one async input
module ctrl_input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_filt,
  output logic o_filt_q
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   r_filt_q;
  logic                   w_s;
  assign w_s = r_sync[SYNC_STAGES-1];
  // r_cnt counts consecutive samples disagreeing with the filtered level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '1;
      r_cnt    <= '0;
      r_filt   <= 1'b1;
      r_filt_q <= 1'b1;
    end else begin
      r_sync   <= SYNC_STAGES'({r_sync, i_raw});
      r_filt_q <= r_filt;
      if (w_s == r_filt) r_cnt <= '0;
      else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_filt <= w_s;
        r_cnt  <= '0;
      end else r_cnt <= r_cnt + CW'(1);
    end
  end
  assign o_filt   = r_filt;
  assign o_filt_q = r_filt_q;
endmodule

// File: rtl/custom_controller_device.sv
// custom_controller_device: snapshots active-low buttons while latch is low and shifts them out MSB first on filtered pulse edges
module custom_controller_device import custom_controller_pkg::*; #(
  parameter int NUM_BUTTONS = CTRL_NUM_BUTTONS,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input logic clk,
  input logic rst,
  custom_controller_device_if.slave bus
);
  localparam int CW = $clog2(NUM_BUTTONS);
  ctrl_dev_state_t        r_state;
  logic [NUM_BUTTONS-1:0] r_btn_sync [SYNC_STAGES];
  logic [NUM_BUTTONS-1:0] r_shift;
  logic [CW-1:0]          r_cnt;
  logic                   r_data;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_latch_f;
  logic                   w_latch_q;
  logic                   w_pulse_f;
  logic                   w_pulse_q;
  logic                   w_latch_rise;
  logic                   w_latch_fall;
  logic                   w_pulse_rise;
  logic [NUM_BUTTONS-1:0] w_btn;
  ctrl_input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_latch (
    .clk(clk), .rst(rst), .i_raw(bus.latch), .o_filt(w_latch_f), .o_filt_q(w_latch_q)
  );
  ctrl_input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_pulse (
    .clk(clk), .rst(rst), .i_raw(bus.pulse), .o_filt(w_pulse_f), .o_filt_q(w_pulse_q)
  );
  assign w_latch_rise = w_latch_f & ~w_latch_q;
  assign w_latch_fall = ~w_latch_f & w_latch_q;
  assign w_pulse_rise = w_pulse_f & ~w_pulse_q;
  assign w_btn        = r_btn_sync[SYNC_STAGES-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_btn_sync[k] <= '1;
    end else begin
      r_btn_sync[0] <= bus.btn_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_btn_sync[k] <= r_btn_sync[k-1];
    end
  end
  // latch handling is checked before pulse edges so a coincident pulse is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
      r_shift <= '1;
      r_cnt   <= '0;
      r_data  <= CTRL_IDLE_LEVEL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        LOAD: begin
          if (w_latch_rise) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_shift <= w_btn;
            r_data  <= w_btn[NUM_BUTTONS-1];
          end
        end
        SHIFT: begin
          if (w_latch_fall) begin
            r_state <= LOAD;
            r_busy  <= 1'b0;
          end else if (w_pulse_rise) begin
            r_shift <= {r_shift[NUM_BUTTONS-2:0], CTRL_IDLE_LEVEL};
            r_data  <= r_shift[NUM_BUTTONS-2];
            if (r_cnt == CW'(NUM_BUTTONS - 1)) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          r_data  <= CTRL_IDLE_LEVEL;
          r_state <= w_latch_f ? DONE : LOAD;
        end
        default: r_state <= LOAD;
      endcase
    end
  end
  assign bus.data       = r_data;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;
endmodule

// File: tb/tb_custom_controller_device.sv
// tb_custom_controller_device: random and directed host frames checked against a window-based behavioural model
module tb_custom_controller_device;
  localparam int NB = 8;
  localparam int SS = 2;
  localparam int FL = 4;
  localparam int HL = SS + FL;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;
  int rise_cyc = 0;
  custom_controller_device_if #(.NUM_BUTTONS(NB)) bus();
  custom_controller_device #(.NUM_BUTTONS(NB), .SYNC_STAGES(SS), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  bit       lh [HL];
  bit       ph [HL];
  bit [7:0] bh [HL];
  bit fl0, fl1, fl2, fp0, fp1, fp2;
  int       m_mode;
  int       m_idx;
  bit [7:0] m_snap;
  bit       m_data, m_busy, m_done;
  // a filtered level takes value v once the delayed sample window is entirely v
  function automatic bit settle(input bit h [HL], input bit cur);
    bit v = h[SS];
    for (int k = SS + 1; k < HL; k++) if (h[k] != v) return cur;
    return v;
  endfunction
  initial forever begin
    bit lr, lf, pr;
    @(posedge clk);
    cyc++;
    if (rst) begin
      for (int k = 0; k < HL; k++) begin lh[k] = 1; ph[k] = 1; bh[k] = '1; end
      fl0 = 1; fl1 = 1; fp0 = 1; fp1 = 1;
      m_mode = 0; m_idx = 0; m_snap = '1; m_data = 1; m_busy = 0; m_done = 0;
    end else begin
      for (int k = HL - 1; k > 0; k--) begin lh[k] = lh[k-1]; ph[k] = ph[k-1]; bh[k] = bh[k-1]; end
      lh[0] = bus.latch; ph[0] = bus.pulse; bh[0] = bus.btn_in;
      fl2 = fl1; fl1 = fl0; fl0 = settle(lh, fl0);
      fp2 = fp1; fp1 = fp0; fp0 = settle(ph, fp0);
      lr = fl1 & !fl2; lf = !fl1 & fl2; pr = fp1 & !fp2;
      m_done = 0;
      if (m_mode == 0) begin
        if (lr) begin m_mode = 1; m_idx = 0; m_busy = 1; end
        else begin m_snap = bh[SS]; m_data = m_snap[NB-1]; end
      end else if (m_mode == 1) begin
        if (lf) begin m_mode = 0; m_busy = 0; end
        else if (pr) begin
          m_idx++;
          if (m_idx == NB) begin m_mode = 2; m_busy = 0; m_done = 1; m_data = 1; end
          else m_data = m_snap[NB-1-m_idx];
        end
      end else begin
        m_data = 1;
        if (!fl1) m_mode = 0;
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    chk("data", bus.data, m_data);
    chk("busy", bus.busy, m_busy);
    chk("frame_done", bus.frame_done, m_done);
    if (bus.frame_done) begin fd_cnt++; fd_cyc = cyc; end
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic run_frame(input bit [7:0] b, input bit [7:0] b2, input int low_len, input int half,
                           input int npulse, input int abort_at, output bit [7:0] seen);
    seen = '1;
    bus.btn_in = b; bus.latch = 0; bus.pulse = 0;
    wait_cyc(low_len);
    bus.latch = 1;
    for (int i = 0; i < npulse; i++) begin
      wait_cyc(half / 2);
      if (i < NB) seen[NB-1-i] = bus.data;
      if (i == 0) bus.btn_in = b2;
      wait_cyc(half - half / 2);
      bus.pulse = 1; rise_cyc = cyc;
      wait_cyc(half);
      bus.pulse = 0;
      if (i + 1 == abort_at) begin bus.latch = 0; break; end
    end
    wait_cyc(20);
  endtask
  initial begin
    bit [7:0] seen, b, b2;
    bus.latch = 1'($urandom); bus.pulse = 1'($urandom); bus.btn_in = 8'($urandom);
    wait_cyc(3);
    chk("rst_data", bus.data, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.frame_done, 0);
    rst = 0; bus.latch = 0; bus.pulse = 0; bus.btn_in = 8'h5A;
    wait_cyc(12);
    chk("load_data", bus.data, 0);
    chk("load_busy", bus.busy, 0);
    fd_cnt = 0;
    run_frame(8'b1010_0110, 8'b1010_0110, 601, 300, 8, 0, seen);
    chk("full_bits", seen, 8'b1010_0110);
    chk("full_done_cnt", fd_cnt, 1);
    chk("full_done_lat", fd_cyc - rise_cyc, 7);
    chk("full_idle", bus.data, 1);
    b = 8'($urandom) & 8'h7F;
    bus.btn_in = b; bus.latch = 0; wait_cyc(30);
    bus.latch = 1; wait_cyc(20);
    chk("glitch_pre", bus.data, b[7]);
    bus.pulse = 1; wait_cyc(2); bus.pulse = 0; wait_cyc(20);
    chk("glitch_data", bus.data, b[7]);
    chk("glitch_busy", bus.busy, 1);
    rst = 1; wait_cyc(1); rst = 0;
    chk("midrst_data", bus.data, 1);
    chk("midrst_busy", bus.busy, 0);
    wait_cyc(10);
    fd_cnt = 0;
    b = 8'($urandom);
    run_frame(b, b, 30, 20, 3, 3, seen);
    chk("abort_bits", seen[7:5], b[7:5]);
    chk("abort_done_cnt", fd_cnt, 0);
    chk("abort_busy", bus.busy, 0);
    b2 = 8'($urandom);
    run_frame(b2, b2, 30, 20, 8, 0, seen);
    chk("after_abort_bits", seen, b2);
    chk("after_abort_done", fd_cnt, 1);
    run_frame(8'hFF, 8'h00, 30, 20, 8, 0, seen);
    chk("snapshot_bits", seen, 8'hFF);
    fd_cnt = 0;
    b = 8'($urandom);
    run_frame(b, b, 30, 20, 10, 0, seen);
    chk("extra_bits", seen, b);
    chk("extra_done_cnt", fd_cnt, 1);
    chk("extra_idle", bus.data, 1);
    for (int r = 0; r < 6; r++) begin
      fd_cnt = 0;
      b = 8'($urandom);
      run_frame(b, 8'($urandom), 10 + int'($urandom_range(30)), 16 + int'($urandom_range(24)), 8, 0, seen);
      chk("rand_bits", seen, b);
      chk("rand_done_cnt", fd_cnt, 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
